mcu_mem_arbiter: RTL

MCU_MEM_ARBITER -- requirements
Module: mcu_mem_arbiter

---
 rtl/typedef_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 25 ++
 rtl/mcu_mem_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/typedef_pkg.sv
// Shared types for the load/store memory arbiter: FSM state encoding and
// the last-grant encoding used by the round-robin selector.
package typedef_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DATA  = 2'd2
   } state_e;

   typedef enum logic {
      GNT_LD = 1'b0,
      GNT_ST = 1'b1
   } gnt_e;

   // One-hot grant vector bit positions from the selector
   localparam int unsigned GNT_BIT_LD = 0;
   localparam int unsigned GNT_BIT_ST = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin selector. Purely combinational: a lone
// requester always wins; on a tie the requester not granted last wins.
module rr_arb2
   import typedef_pkg::*;
(
   input  logic       req_ld_i,
   input  logic       req_st_i,
   input  logic       last_gnt_i,
   output logic [1:0] gnt_o
);

   // Pick one winner, one-hot (bit 0 = load, bit 1 = store)
   always_comb begin
      gnt_o = 2'b00;
      if (req_ld_i && req_st_i) begin
         if (last_gnt_i == GNT_ST) gnt_o[GNT_BIT_LD] = 1'b1;
         else                      gnt_o[GNT_BIT_ST] = 1'b1;
      end else if (req_ld_i) begin
         gnt_o[GNT_BIT_LD] = 1'b1;
      end else if (req_st_i) begin
         gnt_o[GNT_BIT_ST] = 1'b1;
      end
   end

endmodule

// File: rtl/mcu_mem_arbiter.sv
// Arbitrates burst requests from the load and store units onto a single
// memory port. A winner is captured in IDLE, its request is presented in
// ISSUE until the port accepts, then DATA counts beats until the last one.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no burst owned; grant the round-robin winner (rdy pulse)
// ISSUE | mem_req_vld_o high with captured fields, wait for mem_req_rdy_i
// DATA  | count mem_beat_i; pulse burst_done_o on the last beat
module mcu_mem_arbiter
   import typedef_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 8
)(
   input  logic              clk,
   input  logic              rstn,
   input  logic              ld_req_vld_i,
   output logic              ld_req_rdy_o,
   input  logic [ADDR_W-1:0] ld_addr_i,
   input  logic [LEN_W-1:0]  ld_len_i,
   input  logic              st_req_vld_i,
   output logic              st_req_rdy_o,
   input  logic [ADDR_W-1:0] st_addr_i,
   input  logic [LEN_W-1:0]  st_len_i,
   output logic              mem_req_vld_o,
   input  logic              mem_req_rdy_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LEN_W-1:0]  mem_len_o,
   output logic              mem_we_o,
   input  logic              mem_beat_i,
   output logic              ld_grant_o,
   output logic              st_grant_o,
   output logic              burst_done_o
);

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic              last_gnt_q, last_gnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              we_q, we_d;
   logic              ld_gnt_q, ld_gnt_d;
   logic              st_gnt_q, st_gnt_d;

   logic [1:0]        arb_gnt;
   logic              accept;
   logic              last_beat;

   rr_arb2 u_rr_arb2 (
      .req_ld_i   (ld_req_vld_i),
      .req_st_i   (st_req_vld_i),
      .last_gnt_i (last_gnt_q),
      .gnt_o      (arb_gnt)
   );

   assign accept    = (state_q == IDLE) && (arb_gnt != 2'b00);
   // Counter stops at len, so len = all-ones finishes without wrapping
   assign last_beat = (state_q == DATA) && mem_beat_i && (cnt_q == len_q);

   // State and datapath registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         last_gnt_q <= GNT_ST;
         addr_q     <= '0;
         len_q      <= '0;
         we_q       <= 1'b0;
         ld_gnt_q   <= 1'b0;
         st_gnt_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_gnt_q <= last_gnt_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         we_q       <= we_d;
         ld_gnt_q   <= ld_gnt_d;
         st_gnt_q   <= st_gnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)        state_d = ISSUE;
         ISSUE:   if (mem_req_rdy_i) state_d = DATA;
         DATA:    if (last_beat)     state_d = IDLE;
         default:                    state_d = IDLE;
      endcase
   end

   // Capture on acceptance, beat counting in DATA, grant hold ISSUE..DATA
   always_comb begin
      cnt_d      = cnt_q;
      last_gnt_d = last_gnt_q;
      addr_d     = addr_q;
      len_d      = len_q;
      we_d       = we_q;
      ld_gnt_d   = ld_gnt_q;
      st_gnt_d   = st_gnt_q;
      if (accept) begin
         ld_gnt_d = arb_gnt[GNT_BIT_LD];
         st_gnt_d = arb_gnt[GNT_BIT_ST];
         if (arb_gnt[GNT_BIT_LD]) begin
            addr_d     = ld_addr_i;
            len_d      = ld_len_i;
            we_d       = 1'b0;
            last_gnt_d = GNT_LD;
         end else begin
            addr_d     = st_addr_i;
            len_d      = st_len_i;
            we_d       = 1'b1;
            last_gnt_d = GNT_ST;
         end
      end
      if (state_q == ISSUE && mem_req_rdy_i) begin
         cnt_d = '0;
      end
      if (state_q == DATA && mem_beat_i) begin
         if (last_beat) begin
            cnt_d    = '0;
            ld_gnt_d = 1'b0;
            st_gnt_d = 1'b0;
         end else begin
            cnt_d = cnt_q + LEN_W'(1);
         end
      end
   end

   // Outputs; the combinational pulses are masked while reset is held so
   // an aborted burst never reports completion
   always_comb begin
      ld_req_rdy_o  = rstn && accept && arb_gnt[GNT_BIT_LD];
      st_req_rdy_o  = rstn && accept && arb_gnt[GNT_BIT_ST];
      mem_req_vld_o = (state_q == ISSUE);
      burst_done_o  = rstn && last_beat;
      mem_addr_o    = addr_q;
      mem_len_o     = len_q;
      mem_we_o      = we_q;
      ld_grant_o    = ld_gnt_q;
      st_grant_o    = st_gnt_q;
   end

endmodule
